// File: rtl/cras_arb_pkg.sv
// Package for the CRAS memory arbiter slice.
// Holds the FSM state and owner encodings plus the shared data/byte-enable
// and wait-counter widths used by cras_mem_arbiter and cras_arb_stats.
package cras_arb_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_RAS  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/cras_arb_stats.sv
// Arbitration statistics counters, instantiated only when ARB_STATS_EN is
// defined.
// Ports:
//   clk, rst         clock and asynchronous active-high reset
//   i_core_gnt       core won arbitration this cycle
//   i_ras_gnt        CRAS won arbitration this cycle
//   i_ras_wait       current CRAS lost-arbitration count
//   o_core_gnt       core grant counter (wraps)
//   o_ras_gnt        CRAS grant counter (wraps)
//   o_ras_maxwait    peak CRAS wait count observed
module cras_arb_stats
  import cras_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_core_gnt,
  input  logic              i_ras_gnt,
  input  logic [WAIT_W-1:0] i_ras_wait,
  output logic [15:0]       o_core_gnt,
  output logic [15:0]       o_ras_gnt,
  output logic [7:0]        o_ras_maxwait
);

  logic [15:0]       r_core_gnt;
  logic [15:0]       r_ras_gnt;
  logic [WAIT_W-1:0] r_ras_maxwait;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_core_gnt    <= '0;
      r_ras_gnt     <= '0;
      r_ras_maxwait <= '0;
    end else begin
      if (i_core_gnt) r_core_gnt <= r_core_gnt + 16'd1;
      if (i_ras_gnt)  r_ras_gnt  <= r_ras_gnt + 16'd1;
      if (i_ras_wait > r_ras_maxwait) r_ras_maxwait <= i_ras_wait;
    end
  end

  assign o_core_gnt    = r_core_gnt;
  assign o_ras_gnt     = r_ras_gnt;
  assign o_ras_maxwait = r_ras_maxwait;

endmodule

// File: rtl/cras_mem_arbiter.sv
// Shares one synchronous data-memory port between the core load/store path
// and the CRAS spill/fill engine. Core has fixed priority; a CRAS request
// that loses MAX_WAIT times gets forced priority.
// Optional feature macro: ARB_STATS_EN (adds stat_* grant/wait counters).
// Ports:
//   clk, Rst                 clock, asynchronous active-high reset
//   core_rd/wr/be/addr/wdata core request (level, held until core_hold==0)
//   core_rdata, core_hold    core load data (valid in RESP), core stall
//   ras_rd/wr/addr/wdata     CRAS request (held until ras_rdy)
//   ras_rdata, ras_rdy       CRAS fill data, one-cycle completion pulse
//   m_en/we/addr/wdata       RAM strobe, byte write enables, address, data
//   m_rdata                  RAM read data, RD_LAT cycles after issue
module cras_mem_arbiter
  import cras_arb_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [BE_W-1:0]   core_be,
  input  logic [WORD_W-1:0] core_addr,
  input  logic [WORD_W-1:0] core_wdata,
  output logic [WORD_W-1:0] core_rdata,
  output logic              core_hold,
  input  logic              ras_rd,
  input  logic              ras_wr,
  input  logic [WORD_W-1:0] ras_addr,
  input  logic [WORD_W-1:0] ras_wdata,
  output logic [WORD_W-1:0] ras_rdata,
  output logic              ras_rdy,
  output logic              m_en,
  output logic [BE_W-1:0]   m_we,
  output logic [WORD_W-1:0] m_addr,
  output logic [WORD_W-1:0] m_wdata,
  input  logic [WORD_W-1:0] m_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]       stat_core_gnt,
  output logic [15:0]       stat_ras_gnt,
  output logic [7:0]        stat_ras_maxwait
`endif
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_V = WAIT_W'(MAX_WAIT);
  // RD_WAIT lasts RD_LAT-1 cycles; the counter is loaded with RD_LAT-2.
  localparam logic [1:0]        LAT_LOAD   = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  arb_state_e        r_state;
  arb_owner_e        r_owner;
  logic [WAIT_W-1:0] r_ras_wait;
  logic [1:0]        r_lat_cnt;
  logic              r_ras_wr_rdy;

  logic w_idle;
  logic w_core_req;
  logic w_ras_busy;
  logic w_ras_req;
  logic w_ras_forced;
  logic w_core_gnt;
  logic w_ras_gnt;
  logic w_resp_core;
  logic w_resp_ras;
  logic w_core_done;

  always_comb begin
    w_idle       = (r_state == IDLE);
    w_core_req   = core_rd | core_wr;
    // CRAS request already in flight (read owned, or write awaiting its
    // ras_rdy pulse) is not a new pending request.
    w_ras_busy   = r_ras_wr_rdy | (~w_idle & (r_owner == OWN_RAS));
    w_ras_req    = (ras_rd | ras_wr) & ~w_ras_busy;
    w_ras_forced = w_ras_req & (r_ras_wait >= MAX_WAIT_V);
    w_core_gnt   = ~Rst & w_idle & w_core_req & ~w_ras_forced;
    w_ras_gnt    = ~Rst & w_idle & w_ras_req & ~w_core_gnt;
    w_resp_core  = ~Rst & (r_state == RESP) & (r_owner == OWN_CORE);
    w_resp_ras   = ~Rst & (r_state == RESP) & (r_owner == OWN_RAS);
    w_core_done  = (w_core_gnt & core_wr) | w_resp_core;
  end

  // RAM port and requester-facing outputs; everything is gated by Rst.
  always_comb begin
    m_en    = w_core_gnt | w_ras_gnt;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    if (w_core_gnt) begin
      m_addr = core_addr;
      if (core_wr) begin
        m_we    = core_be;
        m_wdata = core_wdata;
      end
    end else if (w_ras_gnt) begin
      m_addr = ras_addr;
      if (ras_wr) begin
        m_we    = '1;
        m_wdata = ras_wdata;
      end
    end
    core_hold  = ~Rst & w_core_req & ~w_core_done;
    core_rdata = w_resp_core ? m_rdata : '0;
    ras_rdata  = w_resp_ras ? m_rdata : '0;
    ras_rdy    = w_resp_ras | (~Rst & r_ras_wr_rdy);
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CORE;
      r_ras_wait   <= '0;
      r_lat_cnt    <= '0;
      r_ras_wr_rdy <= 1'b0;
    end else begin
      r_ras_wr_rdy <= w_ras_gnt & ras_wr;

      if (w_ras_gnt)
        r_ras_wait <= '0;
      else if (w_ras_req && (r_ras_wait != MAX_WAIT_V))
        r_ras_wait <= r_ras_wait + 1'b1;

      case (r_state)
        IDLE: begin
          // Writes finish in the issue cycle; only reads leave IDLE.
          if ((w_core_gnt && !core_wr) || (w_ras_gnt && !ras_wr)) begin
            r_owner   <= w_core_gnt ? OWN_CORE : OWN_RAS;
            r_lat_cnt <= LAT_LOAD;
            r_state   <= (RD_LAT == 1) ? RESP : RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (r_lat_cnt == 2'd0) r_state <= RESP;
          else                   r_lat_cnt <= r_lat_cnt - 2'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  cras_arb_stats u_stats (
    .clk          (clk),
    .rst          (Rst),
    .i_core_gnt   (w_core_gnt),
    .i_ras_gnt    (w_ras_gnt),
    .i_ras_wait   (r_ras_wait),
    .o_core_gnt   (stat_core_gnt),
    .o_ras_gnt    (stat_ras_gnt),
    .o_ras_maxwait(stat_ras_maxwait)
  );
`endif

endmodule
